// File: rtl/counter_seek_pkg.sv
// Shared types and the reference next-count model for the counter seek controller.
// The model is also used by the bench scoreboard.
package counter_seek_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EVAL,
        S_PULSE,
        S_CHECK,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        ST_OK       = 2'd0,
        ST_RANGE    = 2'd1,
        ST_MISMATCH = 2'd2,
        ST_TIMEOUT  = 2'd3
    } status_e;

    // Next count of a modulo-mod up/down counter; callers truncate to their width.
    function automatic logic [31:0] ctr_next(input logic [31:0] c, input logic up,
                                             input logic dn, input logic [31:0] mod);
        if (c == mod - 1)
            return 32'd0;
        else if (up && !dn)
            return c + 32'd1;
        else if (!up && dn)
            return c - 32'd1;
        else
            return c;
    endfunction

endpackage

// File: rtl/counter_seek_ctrl.sv
// Drives en/ds pulses into a modulo-MOD up/down counter until it reaches a requested
// target, verifying every step against the reference model.
module counter_seek_ctrl
    import counter_seek_pkg::*;
#(
    parameter int W         = 8,
    parameter int MOD       = 12,
    parameter int MAX_STEPS = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tgt_valid,
    output logic         tgt_ready,
    input  logic [W-1:0] tgt_value,
    input  logic [W-1:0] ctr_in,
    output logic         en,
    output logic         ds,
    output logic         busy,
    output logic         done,
    output logic [1:0]   status,
    output logic [W-1:0] steps
);

    localparam logic [W-1:0] MOD_W     = W'(MOD);
    localparam logic [W-1:0] MOD_TOP   = W'(MOD - 1);
    localparam logic [W-1:0] MAX_W     = W'(MAX_STEPS);

    state_e       state_q,  state_d;
    status_e      status_q, status_d;
    logic [W-1:0] tgt_q,    tgt_d;
    logic [W-1:0] exp_q,    exp_d;
    logic [W-1:0] steps_q,  steps_d;
    logic         en_q,     en_d;
    logic         ds_q,     ds_d;
    logic         done_q,   done_d;

    logic [W-1:0] steps_inc;
    logic         go_up;

    assign steps_inc = steps_q + W'(1);
    assign go_up     = (ctr_in < tgt_q);

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_d  = state_q;
        status_d = status_q;
        tgt_d    = tgt_q;
        exp_d    = exp_q;
        steps_d  = steps_q;
        en_d     = 1'b0;
        ds_d     = 1'b0;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (tgt_valid) begin
                    tgt_d   = tgt_value;
                    steps_d = '0;
                    if (tgt_value >= MOD_W) begin
                        state_d  = S_DONE;
                        status_d = ST_RANGE;
                        done_d   = 1'b1;
                    end else begin
                        state_d = S_EVAL;
                    end
                end
            end
            S_EVAL: begin
                if (ctr_in == tgt_q) begin
                    state_d  = S_DONE;
                    status_d = ST_OK;
                    done_d   = 1'b1;
                end else if (ctr_in == MOD_TOP) begin
                    // Counter wraps on its own at the top; expect 0 without commanding it.
                    exp_d   = W'(ctr_next(32'(ctr_in), 1'b0, 1'b0, MOD));
                    state_d = S_CHECK;
                end else begin
                    exp_d   = W'(ctr_next(32'(ctr_in), go_up, !go_up, MOD));
                    en_d    = go_up;
                    ds_d    = !go_up;
                    state_d = S_PULSE;
                end
            end
            S_PULSE: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (ctr_in != exp_q) begin
                    state_d  = S_DONE;
                    status_d = ST_MISMATCH;
                    done_d   = 1'b1;
                end else begin
                    steps_d = steps_inc;
                    if (steps_inc == MAX_W && ctr_in != tgt_q) begin
                        state_d  = S_DONE;
                        status_d = ST_TIMEOUT;
                        done_d   = 1'b1;
                    end else begin
                        state_d = S_EVAL;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst) begin
            state_q  <= S_IDLE;
            status_q <= ST_OK;
            tgt_q    <= '0;
            exp_q    <= '0;
            steps_q  <= '0;
            en_q     <= 1'b0;
            ds_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            tgt_q    <= tgt_d;
            exp_q    <= exp_d;
            steps_q  <= steps_d;
            en_q     <= en_d;
            ds_q     <= ds_d;
            done_q   <= done_d;
        end
    end

    assign tgt_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign en        = en_q;
    assign ds        = ds_q;
    assign done      = done_q;
    assign status    = status_q;
    assign steps     = steps_q;

endmodule
